// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX FIFO write port among NUM_REQ byte streams.
// A grant covers a whole packet (capped at MAX_BURST bytes) and is revoked after IDLE_TIMEOUT quiet cycles.

module uart_tx_arbiter_chk #(
    parameter int NUM_REQ = 4,
    parameter int GW      = 2
) (
    input logic               clk,
    input logic               reset,
    input logic [NUM_REQ-1:0] req_ready,
    input logic               tx_fifo_writeEn,
    input logic               tx_fifo_Full,
    input logic               busy,
    input logic [GW-1:0]      grant_id
);

    a_write_needs_room: assert property (@(posedge clk) disable iff (reset)
        tx_fifo_writeEn |-> (busy && !tx_fifo_Full));

    a_ready_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0(req_ready));

    a_ready_only_granted: assert property (@(posedge clk) disable iff (reset)
        !busy |-> (req_ready == {NUM_REQ{1'b0}}));

    a_grant_in_range: assert property (@(posedge clk) disable iff (reset)
        busy |-> (int'(grant_id) < NUM_REQ));

endmodule

module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 8,
    localparam int GW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         tx_fifo_dataIn,
    output logic                          tx_fifo_writeEn,
    input  logic                          tx_fifo_Full,
    output logic [GW-1:0]                 grant_id,
    output logic                          busy
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [7:0]    BURST_LIMIT   = 8'(MAX_BURST);
    localparam logic [7:0]    TIMEOUT_LIMIT = 8'(IDLE_TIMEOUT);
    localparam logic [GW-1:0] LAST_IDX      = GW'(NUM_REQ - 1);

    state_t          state_q, state_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]   grant_id_q, grant_id_d;
    logic [7:0]      byte_cnt_q, byte_cnt_d;
    logic [7:0]      idle_cnt_q, idle_cnt_d;

    logic [DATA_WIDTH-1:0] req_bytes_s [NUM_REQ];
    logic                  arb_found_s;
    logic [GW-1:0]         arb_pick_s;
    logic [GW-1:0]         scan_idx_s;
    logic                  in_grant_s;
    logic                  gnt_valid_s;
    logic                  hs_s;
    logic                  release_s;

    // Index increment with an explicit wrap, so NUM_REQ need not be a power of two.
    function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] idx);
        if (idx == LAST_IDX) begin
            return {GW{1'b0}};
        end else begin
            return idx + {{(GW-1){1'b0}}, 1'b1};
        end
    endfunction

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_bytes_s[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin scan: first valid requester starting at rr_ptr.
    always_comb begin
        arb_found_s = 1'b0;
        arb_pick_s  = {GW{1'b0}};
        scan_idx_s  = rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!arb_found_s && req_valid[scan_idx_s]) begin
                arb_found_s = 1'b1;
                arb_pick_s  = scan_idx_s;
            end else begin
                arb_found_s = arb_found_s;
                arb_pick_s  = arb_pick_s;
            end
            scan_idx_s = wrap_inc(scan_idx_s);
        end
    end

    // Handshake and release conditions of the current grant holder.
    always_comb begin
        in_grant_s  = (state_q == ST_GRANT);
        gnt_valid_s = req_valid[grant_id_q];
        hs_s        = in_grant_s & gnt_valid_s & ~tx_fifo_Full;
        // last byte and burst cap on one cycle are still a single release
        release_s   = (hs_s & (req_last[grant_id_q] | ((byte_cnt_q + 8'd1) == BURST_LIMIT)))
                    | (in_grant_s & ~gnt_valid_s & ((idle_cnt_q + 8'd1) == TIMEOUT_LIMIT));
    end

    // Next-state and counter update.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        byte_cnt_d = byte_cnt_q;
        idle_cnt_d = idle_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_found_s) begin
                    state_d    = ST_GRANT;
                    grant_id_d = arb_pick_s;
                    byte_cnt_d = 8'd0;
                    idle_cnt_d = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (hs_s) begin
                    byte_cnt_d = byte_cnt_q + 8'd1;
                    idle_cnt_d = 8'd0;
                end else if (!gnt_valid_s) begin
                    idle_cnt_d = idle_cnt_q + 8'd1;
                end else begin
                    // backpressure: hold both counters
                    idle_cnt_d = idle_cnt_q;
                end
                if (release_s) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = wrap_inc(grant_id_q);
                end else begin
                    state_d = ST_GRANT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= {GW{1'b0}};
            grant_id_q <= {GW{1'b0}};
            byte_cnt_q <= 8'd0;
            idle_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            byte_cnt_q <= byte_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    // Combinational write path from the grant holder to the FIFO; forced quiet in reset.
    always_comb begin
        req_ready       = {NUM_REQ{1'b0}};
        tx_fifo_writeEn = 1'b0;
        tx_fifo_dataIn  = {DATA_WIDTH{1'b0}};
        busy            = 1'b0;
        if (!reset && in_grant_s) begin
            busy                  = 1'b1;
            req_ready[grant_id_q] = ~tx_fifo_Full;
            tx_fifo_writeEn       = hs_s;
            tx_fifo_dataIn        = req_bytes_s[grant_id_q];
        end else begin
            busy = 1'b0;
        end
    end

    assign grant_id = grant_id_q;

    uart_tx_arbiter_chk #(
        .NUM_REQ (NUM_REQ),
        .GW      (GW)
    ) u_chk (
        .clk             (clk),
        .reset           (reset),
        .req_ready       (req_ready),
        .tx_fifo_writeEn (tx_fifo_writeEn),
        .tx_fifo_Full    (tx_fifo_Full),
        .busy            (busy),
        .grant_id        (grant_id)
    );

endmodule
